replay_ctrl: RTL and testbench

Sequencing controller for the data-link replay buffer: assigns 12-bit sequence numbers to outgoing TLP words, writes each word into an external synchronous-read replay RAM, forwards it to the transmit path, and retires entries on ACK DLLPs. On NAK or replay-timer expiry it re-reads every unacknowledged entry in sequence order and retransmits it, escalating to a link-retrain request after repeated replays. It sits between the transaction-layer TLP source, the replay RAM and the physical transmit port.

---
 rtl/replay_pkg.sv | 30 +++
 rtl/replay_timer.sv | 39 +++
 rtl/replay_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_replay_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replay_pkg.sv
// Shared types and sequence-number helpers for the data-link replay controller.
// All sequence arithmetic is modulo 2^SEQ_W; subtraction of seq_t values wraps naturally.
package replay_pkg;

    localparam int SEQ_W = 12;

    typedef logic [SEQ_W-1:0] seq_t;

    localparam seq_t       SEQ_ONE        = 12'd1;
    localparam logic [1:0] REPLAY_NUM_MAX = 2'd3;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        REPLAY_RD = 2'd1,
        REPLAY_TX = 2'd2
    } state_e;

    // An AckNak distance d is forward progress when it retires 1..count entries.
    function automatic logic seq_ack_in_window(input seq_t d, input seq_t count);
        return (d != '0) && (d <= count);
    endfunction

    // True when p lies in [base, base+span] on the modular sequence circle.
    function automatic logic seq_within(input seq_t p, input seq_t base, input seq_t span);
        seq_t off;
        off = p - base;
        return off <= span;
    endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: counts enabled cycles up to TIMER_LIMIT and holds there until cleared.
module replay_timer
    import replay_pkg::*;
#(
    parameter int TIMER_LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMER_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMER_LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LIMIT);

endmodule

// File: rtl/replay_ctrl.sv
// Data-link replay controller: numbers outgoing TLP words, logs them to an external
// replay RAM, retires them on ACK and retransmits the unacknowledged window on NAK/timeout.
module replay_ctrl
    import replay_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 11,
    parameter int TIMER_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tlp_valid,
    output logic              tlp_ready,
    input  logic [DATA_W-1:0] tlp_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic [SEQ_W-1:0]  tx_seq,
    output logic              tx_replay,
    input  logic              dllp_valid,
    input  logic              dllp_nak,
    input  logic [SEQ_W-1:0]  dllp_seq,
    output logic              dllp_err,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              replay_active,
    output logic              link_retrain,
    output logic [SEQ_W-1:0]  outstanding
);

    localparam int   CAPACITY_INT = 1 << ADDR_W;
    localparam seq_t CAPACITY     = SEQ_W'(CAPACITY_INT);

    state_e            state_q, state_d;
    seq_t              next_seq_q, next_seq_d;
    seq_t              ackd_seq_q, ackd_seq_d;
    seq_t              replay_ptr_q, replay_ptr_d;
    logic [1:0]        replay_num_q, replay_num_d;
    logic              replay_wait_q, replay_wait_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    seq_t              tx_seq_q, tx_seq_d;
    logic              tx_replay_q, tx_replay_d;
    logic              dllp_err_q, dllp_err_d;
    logic              link_retrain_q, link_retrain_d;
    logic              alive_q;

    seq_t outstanding_cur;
    seq_t dllp_dist;
    seq_t out_post;
    seq_t restart_seq;
    seq_t ptr_adv;
    logic full;
    logic tx_fire;
    logic tx_free;
    logic tlp_accept;
    logic dllp_progress;
    logic dllp_bad;
    logic replay_req;
    logic timer_clr;
    logic timer_en;
    logic timer_expire;

    assign outstanding_cur = next_seq_q - ackd_seq_q - SEQ_ONE;
    assign full            = (outstanding_cur == CAPACITY);
    assign tx_fire         = tx_valid_q && tx_ready;
    assign tx_free         = !tx_valid_q || tx_ready;
    // alive_q keeps the source stalled for the first cycle out of reset.
    assign tlp_ready       = alive_q && (state_q == NORMAL) && !replay_wait_q && !full && tx_free;
    assign tlp_accept      = tlp_valid && tlp_ready;

    assign dllp_dist       = dllp_seq - ackd_seq_q;
    assign dllp_progress   = dllp_valid && seq_ack_in_window(dllp_dist, outstanding_cur);
    assign dllp_bad        = dllp_valid && (dllp_dist != '0) && !dllp_progress;
    assign timer_en        = (state_q == NORMAL) && (outstanding_cur != '0);

    replay_timer #(
        .TIMER_LIMIT(TIMER_LIMIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        next_seq_d     = next_seq_q;
        ackd_seq_d     = ackd_seq_q;
        replay_ptr_d   = replay_ptr_q;
        replay_num_d   = replay_num_q;
        replay_wait_d  = replay_wait_q;
        tx_valid_d     = tx_valid_q;
        tx_data_d      = tx_data_q;
        tx_seq_d       = tx_seq_q;
        tx_replay_d    = tx_replay_q;
        dllp_err_d     = dllp_bad;
        link_retrain_d = 1'b0;
        timer_clr      = 1'b0;
        buf_rd_en      = 1'b0;
        replay_req     = 1'b0;
        ptr_adv        = replay_ptr_q + SEQ_ONE;

        if (tx_fire) begin
            tx_valid_d = 1'b0;
        end

        // Purge is evaluated against the pre-accept window.
        if (dllp_progress) begin
            ackd_seq_d   = dllp_seq;
            replay_num_d = 2'd0;
            timer_clr    = 1'b1;
        end

        if (tlp_accept) begin
            next_seq_d  = next_seq_q + SEQ_ONE;
            tx_valid_d  = 1'b1;
            tx_data_d   = tlp_data;
            tx_seq_d    = next_seq_q;
            tx_replay_d = 1'b0;
        end

        out_post    = next_seq_d - ackd_seq_d - SEQ_ONE;
        restart_seq = ackd_seq_d + SEQ_ONE;

        case (state_q)
            NORMAL: begin
                replay_req = replay_wait_q
                           || (dllp_valid && !dllp_bad && dllp_nak)
                           || (timer_expire && (outstanding_cur != '0));
                if (replay_req) begin
                    if (out_post == '0) begin
                        replay_wait_d = 1'b0;
                    end else if (!tx_valid_d) begin
                        state_d       = REPLAY_RD;
                        replay_ptr_d  = restart_seq;
                        replay_wait_d = 1'b0;
                        timer_clr     = 1'b1;
                        if (replay_num_d == REPLAY_NUM_MAX) begin
                            link_retrain_d = 1'b1;
                            replay_num_d   = 2'd0;
                        end else begin
                            replay_num_d = replay_num_d + 2'd1;
                        end
                    end else begin
                        replay_wait_d = 1'b1;
                    end
                end
            end

            REPLAY_RD: begin
                buf_rd_en = 1'b1;
                if (!seq_within(replay_ptr_q, restart_seq, out_post)) begin
                    replay_ptr_d = restart_seq;
                    state_d      = (restart_seq == next_seq_q) ? NORMAL : REPLAY_RD;
                end else begin
                    state_d = REPLAY_TX;
                end
            end

            REPLAY_TX: begin
                if (!tx_valid_q) begin
                    // Read data is only valid this cycle; drop it if an ACK just retired it.
                    if (!seq_within(replay_ptr_q, restart_seq, out_post)) begin
                        replay_ptr_d = restart_seq;
                        state_d      = (restart_seq == next_seq_q) ? NORMAL : REPLAY_RD;
                    end else begin
                        tx_valid_d  = 1'b1;
                        tx_data_d   = buf_rd_data;
                        tx_seq_d    = replay_ptr_q;
                        tx_replay_d = 1'b1;
                    end
                end else if (tx_fire) begin
                    if (!seq_within(ptr_adv, restart_seq, out_post)) begin
                        ptr_adv = restart_seq;
                    end
                    replay_ptr_d = ptr_adv;
                    state_d      = (ptr_adv == next_seq_q) ? NORMAL : REPLAY_RD;
                end
            end

            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= NORMAL;
            next_seq_q     <= '0;
            ackd_seq_q     <= '1;
            replay_ptr_q   <= '0;
            replay_num_q   <= 2'd0;
            replay_wait_q  <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
            tx_seq_q       <= '0;
            tx_replay_q    <= 1'b0;
            dllp_err_q     <= 1'b0;
            link_retrain_q <= 1'b0;
            alive_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_seq_q     <= next_seq_d;
            ackd_seq_q     <= ackd_seq_d;
            replay_ptr_q   <= replay_ptr_d;
            replay_num_q   <= replay_num_d;
            replay_wait_q  <= replay_wait_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            tx_seq_q       <= tx_seq_d;
            tx_replay_q    <= tx_replay_d;
            dllp_err_q     <= dllp_err_d;
            link_retrain_q <= link_retrain_d;
            alive_q        <= 1'b1;
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign tx_seq        = tx_seq_q;
    assign tx_replay     = tx_replay_q;
    assign dllp_err      = dllp_err_q;
    assign link_retrain  = link_retrain_q;
    assign replay_active = (state_q != NORMAL);
    assign outstanding   = outstanding_cur;
    assign buf_wr_en     = tlp_accept;
    assign buf_wr_addr   = next_seq_q[ADDR_W-1:0];
    assign buf_wr_data   = tlp_data;
    assign buf_rd_addr   = replay_ptr_q[ADDR_W-1:0];

endmodule

// File: tb/tb_replay_ctrl.sv
// Directed bench for replay_ctrl with a scoreboard of expected transmit words.
module tb_replay_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int TL     = 2500;

    typedef struct packed {
        logic [15:0] data;
        logic [11:0] seq;
        logic        rep;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tlp_valid = 1'b0;
    logic              tlp_ready;
    logic [DATA_W-1:0] tlp_data = '0;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic [DATA_W-1:0] tx_data;
    logic [11:0]       tx_seq;
    logic              tx_replay;
    logic              dllp_valid = 1'b0;
    logic              dllp_nak = 1'b0;
    logic [11:0]       dllp_seq = '0;
    logic              dllp_err;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data = '0;
    logic              replay_active;
    logic              link_retrain;
    logic [11:0]       outstanding;

    logic [DATA_W-1:0] ram [2048];
    logic [15:0]       sent_data [4096];
    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [11:0]       model_next = '0;
    int                word_idx = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    replay_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMER_LIMIT (TL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tlp_valid     (tlp_valid),
        .tlp_ready     (tlp_ready),
        .tlp_data      (tlp_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_seq        (tx_seq),
        .tx_replay     (tx_replay),
        .dllp_valid    (dllp_valid),
        .dllp_nak      (dllp_nak),
        .dllp_seq      (dllp_seq),
        .dllp_err      (dllp_err),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_data   (buf_wr_data),
        .buf_rd_en     (buf_rd_en),
        .buf_rd_addr   (buf_rd_addr),
        .buf_rd_data   (buf_rd_data),
        .replay_active (replay_active),
        .link_retrain  (link_retrain),
        .outstanding   (outstanding)
    );

    initial forever #5 clk = ~clk;

    // External synchronous-read replay RAM.
    always @(posedge clk) begin
        if (buf_wr_en) ram[buf_wr_addr] <= buf_wr_data;
        if (buf_rd_en) buf_rd_data <= ram[buf_rd_addr];
    end

    // Transmit monitor: every handshake pops and checks one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL tx_unexpected: observed seq %0d data %h replay %0b, required no word", tx_seq, tx_data, tx_replay);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                $display("tx word seq=%0d data=%h replay=%0b", tx_seq, tx_data, tx_replay);
                n_checks++;
                assert ({tx_data, tx_seq, tx_replay} === {mon_e.data, mon_e.seq, mon_e.rep}) else begin
                    n_fail++;
                    $error("FAIL tx_word: observed data %h seq %0d replay %0b, required data %h seq %0d replay %0b",
                           tx_data, tx_seq, tx_replay, mon_e.data, mon_e.seq, mon_e.rep);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] mkdata(input int i);
        return 16'(i * 941 + 16'h1234);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        tlp_valid  = 1'b0;
        dllp_valid = 1'b0;
        dllp_nak   = 1'b0;
        tx_ready   = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        model_next = '0;
    endtask

    task automatic send_words(input int n);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        tlp_valid = 1'b1;
        tlp_data  = mkdata(word_idx);
        while (sent < n && guard < n * 4 + 100) begin
            @(negedge clk);
            if (tlp_ready) begin
                chk("wr_port", 64'({buf_wr_en, buf_wr_addr, buf_wr_data}),
                    64'({1'b1, model_next[ADDR_W-1:0], tlp_data}));
                exp_q.push_back('{data: tlp_data, seq: model_next, rep: 1'b0});
                sent_data[model_next] = tlp_data;
                model_next = model_next + 12'd1;
                word_idx++;
                sent++;
            end
            @(posedge clk);
            #1;
            tlp_data = mkdata(word_idx);
            guard++;
        end
        tlp_valid = 1'b0;
        if (sent < n) chk("send_timeout", 64'(sent), 64'(n));
    endtask

    task automatic send_dllp(input logic nak, input logic [11:0] seq, output logic err);
        dllp_valid = 1'b1;
        dllp_nak   = nak;
        dllp_seq   = seq;
        @(posedge clk);
        #1;
        dllp_valid = 1'b0;
        dllp_nak   = 1'b0;
        err        = dllp_err;
        $display("dllp %s seq=%0d err=%0b outstanding=%0d", nak ? "NAK" : "ACK", seq, err, outstanding);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || tx_valid || replay_active) && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20000) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_tx_valid();
        int guard;
        guard = 0;
        while (!tx_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) chk("tx_valid_timeout", 64'(tx_valid), 64'(1));
    endtask

    initial begin
        logic err;
        int   cnt;
        int   rem;

        // Reset state, sampled while reset is held.
        rst_n = 1'b0;
        #12;
        chk("reset_outputs",
            64'({tx_valid, tlp_ready, buf_wr_en, buf_rd_en, dllp_err, link_retrain,
                 replay_active, outstanding, tx_seq, tx_data}), 64'(0));
        do_reset();

        // Three words then a cumulative ACK.
        send_words(3);
        wait_drain();
        chk("out_after_3", 64'(outstanding), 64'(3));
        send_dllp(1'b0, 12'd2, err);
        chk("ack2_err", 64'(err), 64'(0));
        chk("ack2_out", 64'(outstanding), 64'(0));

        // NAK replays the remaining window with original data.
        do_reset();
        send_words(5);
        wait_drain();
        send_dllp(1'b1, 12'd1, err);
        for (int s = 2; s <= 4; s++) exp_q.push_back('{data: sent_data[s], seq: 12'(s), rep: 1'b1});
        chk("nak_err", 64'(err), 64'(0));
        chk("nak_replay_start", 64'({replay_active, buf_rd_en, buf_rd_addr}), 64'({2'b11, 11'd2}));
        wait_drain();
        chk("nak_replay_end", 64'({replay_active, outstanding}), 64'({1'b0, 12'd3}));

        // Timer-driven replays, retrain on the fourth.
        do_reset();
        send_words(1);
        for (int r = 0; r < 4; r++) begin
            cnt = 0;
            while (!replay_active && cnt < TL + 20) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            chk("timer_expiry_cycles", 64'(cnt), 64'(TL + 1));
            chk("retrain_pulse", 64'(link_retrain), 64'(r == 3));
            exp_q.push_back('{data: sent_data[0], seq: 12'd0, rep: 1'b1});
            @(posedge clk);
            #1;
            chk("retrain_one_cycle", 64'(link_retrain), 64'(0));
            wait_drain();
        end

        // Fill the window, then free one slot.
        do_reset();
        send_words(2048);
        chk("full_state", 64'({tlp_ready, outstanding}), 64'({1'b0, 12'd2048}));
        wait_drain();
        chk("full_ready", 64'(tlp_ready), 64'(0));
        send_dllp(1'b0, 12'd0, err);
        chk("full_ack_state", 64'({err, tlp_ready, outstanding}), 64'({2'b01, 12'd2047}));
        send_words(1);
        wait_drain();

        // Walk the sequence counter up to the wrap point.
        while (model_next != 12'd4094) begin
            send_dllp(1'b0, model_next - 12'd1, err);
            rem = 4094 - int'(model_next);
            send_words(rem > 500 ? 500 : rem);
            wait_drain();
        end
        send_dllp(1'b0, model_next - 12'd1, err);
        chk("wrap_clear", 64'({err, outstanding}), 64'(0));
        send_words(3);
        wait_drain();
        chk("wrap_out", 64'(outstanding), 64'(3));
        send_dllp(1'b0, 12'd100, err);
        chk("bad_ack_err", 64'({err, outstanding}), 64'({1'b1, 12'd3}));
        @(posedge clk);
        #1;
        chk("bad_ack_pulse", 64'(dllp_err), 64'(0));
        send_dllp(1'b0, 12'd0, err);
        chk("wrap_ack", 64'({err, outstanding}), 64'(0));

        // ACK arriving mid-replay moves the replay pointer forward.
        do_reset();
        send_words(6);
        wait_drain();
        send_dllp(1'b0, 12'd0, err);
        tx_ready = 1'b0;
        send_dllp(1'b1, 12'd0, err);
        exp_q.push_back('{data: sent_data[1], seq: 12'd1, rep: 1'b1});
        wait_tx_valid();
        chk("replay_first", 64'({tx_seq, tx_replay}), 64'({12'd1, 1'b1}));
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        wait_tx_valid();
        chk("replay_second", 64'(tx_seq), 64'(2));
        send_dllp(1'b0, 12'd3, err);
        chk("mid_ack", 64'({err, replay_active, outstanding}), 64'({2'b01, 12'd2}));
        exp_q.push_back('{data: sent_data[2], seq: 12'd2, rep: 1'b1});
        exp_q.push_back('{data: sent_data[4], seq: 12'd4, rep: 1'b1});
        exp_q.push_back('{data: sent_data[5], seq: 12'd5, rep: 1'b1});
        tx_ready = 1'b1;
        wait_drain();
        chk("mid_ack_done", 64'({replay_active, outstanding}), 64'({1'b0, 12'd2}));

        // Reset asserted in the middle of a replay.
        send_dllp(1'b1, 12'd3, err);
        chk("replay_before_reset", 64'(replay_active), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_replay",
            64'({tx_valid, tlp_ready, buf_wr_en, buf_rd_en, dllp_err, link_retrain,
                 replay_active, outstanding, tx_seq, tx_data}), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("after_reset_idle", 64'({tx_valid, replay_active, outstanding}), 64'(0));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
